// File: rtl/calc_time_arbiter_if.sv
// Signal bundle between the calc_time arbiter, its requesters and the shared core.
interface calc_time_arbiter_if #(
    parameter int N_REQ = 5
);
    logic [N_REQ-1:0]     req;
    logic [N_REQ*160-1:0] params_in;
    logic                 core_start;
    logic [159:0]         core_params;
    logic [255:0]         core_timing;
    logic                 core_finish;
    logic [N_REQ-1:0]     grant;
    logic [N_REQ-1:0]     done;
    logic [N_REQ-1:0]     error;
    logic [255:0]         result;
    logic                 busy;

    modport slave (
        input  req, params_in, core_timing, core_finish,
        output core_start, core_params, grant, done, error, result, busy
    );

    modport master (
        output req, params_in, core_timing, core_finish,
        input  core_start, core_params, grant, done, error, result, busy
    );
endinterface

// File: rtl/calc_time_arbiter.sv
// Round-robin sharing of one calc_time core between N_REQ requesters, with a
// settle gap between jobs, per-job timeout and abort when a requester drops req.
module calc_time_arb_lane (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic sel_i,
    input  logic end_ok_i,
    input  logic end_err_i,
    input  logic end_any_i,
    output logic grant_o,
    output logic done_o,
    output logic error_o
);
    logic grant_q, grant_d;
    logic done_q, done_d;
    logic error_q, error_d;

    // done/error are qualified by this lane's grant so only the owner pulses
    always_comb begin
        grant_d = grant_q;
        if (load_i && sel_i) grant_d = 1'b1;
        else if (end_any_i)  grant_d = 1'b0;
        done_d  = end_ok_i  && grant_q;
        error_d = end_err_i && grant_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            grant_q <= grant_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign grant_o = grant_q;
    assign done_o  = done_q;
    assign error_o = error_q;
endmodule

module calc_time_arbiter #(
    parameter int          N_REQ      = 5,
    parameter int unsigned GAP_CYCLES = 20,
    parameter logic [31:0] TIMEOUT    = 32'd1000000
) (
    input logic clk,
    input logic reset,
    calc_time_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam logic [IW-1:0] PTR_RST = IW'(N_REQ - 1);
    localparam logic [15:0]   GAP_LD  = 16'(GAP_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [31:0]   tcnt_q, tcnt_d;
    logic [15:0]   gcnt_q, gcnt_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic [159:0]  cparams_q, cparams_d;
    logic [255:0]  result_q, result_d;

    logic [IW-1:0] win;
    logic          any_req;
    logic          load, end_ok, end_err, end_any;
    logic [N_REQ-1:0] grant_v, done_v, error_v;

    // First set req bit after ptr, wrapping; scanning far-to-near lets the
    // nearest candidate overwrite the others.
    always_comb begin
        int idx;
        idx     = 0;
        win     = ptr_q;
        any_req = |bus.req;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (bus.req[idx]) win = idx[IW-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        tcnt_d    = tcnt_q;
        gcnt_d    = gcnt_q;
        start_d   = start_q;
        busy_d    = busy_q;
        cparams_d = cparams_q;
        result_d  = result_q;
        load      = 1'b0;
        end_ok    = 1'b0;
        end_err   = 1'b0;
        end_any   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    load      = 1'b1;
                    ptr_d     = win;
                    cparams_d = bus.params_in[int'(win)*160 +: 160];
                    start_d   = 1'b1;
                    tcnt_d    = 32'd0;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                // ptr holds the current owner; abort outranks finish outranks timeout
                if (!bus.req[ptr_q]) begin
                    end_any = 1'b1;
                end else if (bus.core_finish) begin
                    end_ok   = 1'b1;
                    end_any  = 1'b1;
                    result_d = bus.core_timing;
                end else if (tcnt_q == TIMEOUT - 32'd1) begin
                    end_err = 1'b1;
                    end_any = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 32'd1;
                end
                if (end_any) begin
                    start_d = 1'b0;
                    gcnt_d  = GAP_LD;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                // leave only once the core has dropped finish from the last job
                if (gcnt_q != 16'd0) begin
                    gcnt_d = gcnt_q - 16'd1;
                end else if (!bus.core_finish) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= PTR_RST;
            tcnt_q    <= 32'd0;
            gcnt_q    <= 16'd0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            cparams_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            tcnt_q    <= tcnt_d;
            gcnt_q    <= gcnt_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            cparams_q <= cparams_d;
            result_q  <= result_d;
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        calc_time_arb_lane u_lane (
            .clk       (clk),
            .reset     (reset),
            .load_i    (load),
            .sel_i     (win == IW'(i)),
            .end_ok_i  (end_ok),
            .end_err_i (end_err),
            .end_any_i (end_any),
            .grant_o   (grant_v[i]),
            .done_o    (done_v[i]),
            .error_o   (error_v[i])
        );
    end

    assign bus.core_start  = start_q;
    assign bus.core_params = cparams_q;
    assign bus.result      = result_q;
    assign bus.busy        = busy_q;
    assign bus.grant       = grant_v;
    assign bus.done        = done_v;
    assign bus.error       = error_v;
endmodule

// File: tb/tb_calc_time_arbiter.sv
// Directed bench for calc_time_arbiter with a small behavioural calc_time core.
module tb_calc_time_arbiter;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    logic model_en;
    logic force_fin;
    int   fin_lat;
    int   start_cnt;

    calc_time_arbiter_if #(.N_REQ(5)) bus ();

    calc_time_arbiter #(
        .N_REQ      (5),
        .GAP_CYCLES (20),
        .TIMEOUT    (32'd50)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // core raises finish fin_lat cycles after start and holds it until start drops
    always @(posedge clk or negedge reset) begin
        if (!reset) start_cnt <= 0;
        else        start_cnt <= bus.core_start ? start_cnt + 1 : 0;
    end
    assign bus.core_finish = force_fin | (model_en && (start_cnt >= fin_lat));

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic wait_grant(output logic [4:0] g, output int lows, output logic [4:0] dacc);
        int t;
        t = 0; lows = 0; dacc = '0;
        while (bus.grant != 0 && t < 500) begin
            @(negedge clk); t++;
            dacc |= bus.done;
            if (!bus.core_start) lows++;
        end
        while (bus.grant == 0 && t < 500) begin
            @(negedge clk); t++;
            dacc |= bus.done;
            if (!bus.core_start && bus.grant == 0) lows++;
        end
        g = bus.grant;
        if (bus.grant == 0) chk("grant_timeout", 0, 1);
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while ((bus.done | bus.error) == 0 && n < 500) begin
            @(negedge clk); n++;
        end
        if ((bus.done | bus.error) == 0) chk("end_timeout", 0, 1);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy && n < 500) begin
            @(negedge clk); n++;
        end
        if (bus.busy) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        logic [255:0] t1, t2;
        logic [159:0] p0;
        logic [4:0]   g, dacc, one;
        int           lows, n;
        int           ord [6];

        n_chk = 0; n_err = 0;
        t1  = {64'd4, 64'd3, 64'd2, 64'd1};
        t2  = {64'd8, 64'd7, 64'd6, 64'd5};
        p0  = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
        one = 5'b00001;
        ord = '{0, 1, 2, 3, 4, 0};

        reset = 1'b0;
        model_en = 1'b1; force_fin = 1'b0; fin_lat = 10;
        bus.req = '0;
        bus.params_in = '0;
        bus.core_timing = t1;
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 5; k++)
                bus.params_in[i*160 + k*32 +: 32] = 32'(i*16 + k + 1);

        // reset state
        tick(2);
        chk("rst_start",  bus.core_start, 0);
        chk("rst_grant",  bus.grant, 0);
        chk("rst_busy",   bus.busy, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_params", bus.core_params, 0);
        chk("rst_doneerr", {bus.done, bus.error}, 0);
        reset = 1'b1;
        tick(1);

        // single job on requester 0
        bus.req = 5'b00001;
        tick(1);
        chk("s_start",  bus.core_start, 1);
        chk("s_grant",  bus.grant, 5'b00001);
        chk("s_busy",   bus.busy, 1);
        chk("s_params", bus.core_params, p0);
        wait_end(n);
        chk("s_done_lat", n, 11);
        chk("s_done",   bus.done, 5'b00001);
        chk("s_result", bus.result, t1);
        chk("s_start_lo", bus.core_start, 0);
        bus.req = '0;
        wait_idle(n);
        chk("s_idle_lat", n, 21);
        chk("s_done_clr", bus.done, 0);
        chk("s_params_hold", bus.core_params, p0);

        // round robin with every requester pending
        do_reset();
        bus.req = 5'b11111;
        for (int j = 0; j < 6; j++) begin
            wait_grant(g, lows, dacc);
            chk($sformatf("rr_grant%0d", j), g, one << ord[j]);
            if (j > 0) chk($sformatf("rr_gap%0d", j), lows >= 21, 1);
        end
        bus.req = '0;
        wait_idle(n);

        // timeout on requester 3, core never finishes
        model_en = 1'b0;
        bus.req = 5'b01000;
        wait_grant(g, lows, dacc);
        chk("to_grant", g, 5'b01000);
        wait_end(n);
        chk("to_lat",    n, 50);
        chk("to_error",  bus.error, 5'b01000);
        chk("to_nodone", bus.done, 0);
        chk("to_start",  bus.core_start, 0);
        chk("to_result", bus.result, t1);
        tick(1);
        chk("to_err_clr", bus.error, 0);
        bus.req = '0;
        wait_idle(n);

        // abort: req[2] drops on the same cycle finish appears
        do_reset();
        bus.core_timing = t2;
        bus.req = 5'b10100;
        wait_grant(g, lows, dacc);
        chk("ab_grant", g, 5'b00100);
        tick(4);
        bus.req = 5'b10000;
        force_fin = 1'b1;
        tick(1);
        force_fin = 1'b0;
        chk("ab_nodone", bus.done, 0);
        chk("ab_noerr",  bus.error, 0);
        chk("ab_grant0", bus.grant, 0);
        chk("ab_start",  bus.core_start, 0);
        chk("ab_gap",    bus.busy, 1);
        chk("ab_result", bus.result, 0);
        model_en = 1'b1;
        wait_grant(g, lows, dacc);
        chk("ab_next",   g, 5'b10000);
        chk("ab_nodone_gap", dacc, 0);
        wait_end(n);
        chk("ab_done4",  bus.done, 5'b10000);
        chk("ab_result4", bus.result, t2);
        bus.req = '0;
        wait_idle(n);

        // sticky finish holds the arbiter in GAP
        bus.req = 5'b00001;
        wait_grant(g, lows, dacc);
        chk("sf_grant", g, 5'b00001);
        wait_end(n);
        chk("sf_done", bus.done, 5'b00001);
        bus.req = 5'b00010;
        force_fin = 1'b1;
        tick(29);
        chk("sf_hold_busy",  bus.busy, 1);
        chk("sf_hold_grant", bus.grant, 0);
        tick(1);
        force_fin = 1'b0;
        tick(1);
        chk("sf_idle", bus.busy, 0);
        tick(1);
        chk("sf_next", bus.grant, 5'b00010);
        chk("sf_next_start", bus.core_start, 1);

        // async reset in the middle of RUN
        tick(3);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_start", bus.core_start, 0);
        chk("ar_grant", bus.grant, 0);
        chk("ar_busy",  bus.busy, 0);
        @(negedge clk);
        bus.req = 5'b00011;
        reset = 1'b1;
        wait_grant(g, lows, dacc);
        chk("ar_first", g, 5'b00001);
        bus.req = '0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
